// File: rtl/ahb_mtx_input_stage_if.sv
// Master-side AHB signals between one bus master and its bus-matrix input stage.
interface ahb_mtx_input_stage_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  HSELS;
  logic [ADDR_WIDTH-1:0] HADDRS;
  logic [1:0]            HTRANSS;
  logic                  HWRITES;
  logic [2:0]            HSIZES;
  logic [2:0]            HBURSTS;
  logic [3:0]            HPROTS;
  logic                  HMASTLOCKS;
  logic                  HREADYS;
  logic                  HREADYOUTS;
  logic                  HRESPS;

  modport master (
    output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS, HREADYS,
    input  HREADYOUTS, HRESPS
  );

  modport slave (
    input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS, HMASTLOCKS, HREADYS,
    output HREADYOUTS, HRESPS
  );
endinterface

// File: rtl/ahb_mtx_input_stage.sv
// Per-master AHB bus-matrix input stage: holds an ungranted address phase and stalls the master.
// Optional feature: define AHB_MTX_ERR_CANCEL_EN to cancel a pending transfer on an ERROR response.
module ahb_mtx_input_stage #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  ahb_mtx_input_stage_if.slave  ahb,
  input  logic                  addr_grant,
  input  logic                  HREADYM_in,
  input  logic                  HRESPM_in,
  output logic                  req_out,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic [1:0]            trans_out,
  output logic                  write_out,
  output logic [2:0]            size_out,
  output logic [2:0]            burst_out,
  output logic [3:0]            prot_out,
  output logic                  lock_out,
  output logic                  sel_out
);

  // Encoding is {pend, dphase}
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    DATA      = 2'b01,
    PEND      = 2'b10,
    DATA_PEND = 2'b11
  } state_t;

  state_t                state_q, state_d;
  logic                  pend, dphase;
  logic                  live_valid, capture;
  logic                  cancel_evt, cancelled_q;
  logic                  hold_sel, hold_write, hold_lock;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [1:0]            hold_trans;
  logic [2:0]            hold_size, hold_burst;
  logic [3:0]            hold_prot;

  assign pend   = state_q[1];
  assign dphase = state_q[0];

`ifdef AHB_MTX_ERR_CANCEL_EN
  // The first ERROR cycle drops the held address; the master reissues after the response
  assign cancel_evt = pend & dphase & HRESPM_in & ~HREADYM_in & ~addr_grant;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      cancelled_q <= 1'b0;
    else if (cancelled_q & HREADYM_in)
      cancelled_q <= 1'b0;
    else if (cancel_evt)
      cancelled_q <= 1'b1;
  end
`else
  assign cancel_evt  = 1'b0;
  assign cancelled_q = 1'b0;
`endif

  assign live_valid = ahb.HSELS & ahb.HREADYS & ahb.HTRANSS[1] & ~cancelled_q;
  assign capture    = live_valid & ~addr_grant & ~pend;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:
        if (live_valid)
          state_d = addr_grant ? DATA : PEND;
      PEND:
        if (addr_grant)
          state_d = DATA;
      DATA:
        if (HREADYM_in) begin
          if (live_valid)
            state_d = addr_grant ? DATA : PEND;
          else
            state_d = IDLE;
        end else if (live_valid & ~addr_grant) begin
          state_d = DATA_PEND;
        end
      DATA_PEND:
        if (cancel_evt)
          state_d = DATA;
        else if (HREADYM_in)
          state_d = addr_grant ? DATA : PEND;
        else if (addr_grant)
          state_d = DATA;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      hold_sel   <= 1'b0;
      hold_addr  <= '0;
      hold_trans <= 2'b00;
      hold_write <= 1'b0;
      hold_size  <= 3'b000;
      hold_burst <= 3'b000;
      hold_prot  <= 4'b0000;
      hold_lock  <= 1'b0;
    end else if (capture) begin
      hold_sel   <= ahb.HSELS;
      hold_addr  <= ahb.HADDRS;
      hold_trans <= ahb.HTRANSS;
      hold_write <= ahb.HWRITES;
      hold_size  <= ahb.HSIZES;
      hold_burst <= ahb.HBURSTS;
      hold_prot  <= ahb.HPROTS;
      hold_lock  <= ahb.HMASTLOCKS;
    end
  end

  // Arbiters see the held transfer (including its lock) for as long as it is pending
  always_comb begin
    sel_out   = pend ? hold_sel   : ahb.HSELS;
    addr_out  = pend ? hold_addr  : ahb.HADDRS;
    trans_out = pend ? hold_trans : ahb.HTRANSS;
    write_out = pend ? hold_write : ahb.HWRITES;
    size_out  = pend ? hold_size  : ahb.HSIZES;
    burst_out = pend ? hold_burst : ahb.HBURSTS;
    prot_out  = pend ? hold_prot  : ahb.HPROTS;
    lock_out  = pend ? hold_lock  : ahb.HMASTLOCKS;
    if (cancelled_q)
      trans_out = 2'b00;
  end

  assign req_out        = pend | live_valid;
  assign ahb.HREADYOUTS = pend ? 1'b0 : (dphase ? HREADYM_in : 1'b1);
  assign ahb.HRESPS     = dphase ? HRESPM_in : 1'b0;

endmodule
